// File: rtl/sha256_msg_block_ctrl.sv
// Loads one SHA-256 message block from byte memory, pads it, and streams 16 big-endian words.
// Optional feature macro MSG_LENGTH_CHECK_EN: reject oversize lengths with a len_error pulse instead of clamping.
module sha256_msg_block_ctrl #(
  parameter int MAX_MESSAGE_LENGTH = 55,
  localparam int AW = $clog2(MAX_MESSAGE_LENGTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] msg_length,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [7:0]    mem_data,
  output logic [31:0]   word_out,
  output logic [3:0]    word_index,
  output logic          word_valid,
  input  logic          word_ready,
  output logic          busy,
`ifdef MSG_LENGTH_CHECK_EN
  output logic          done,
  output logic          len_error
`else
  output logic          done
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EMIT, S_DONE} state_t;

  state_t        state_reg;
  logic [1:0]    cnt_reg;
  logic          prime_reg;
  logic [AW-1:0] len_reg;
  logic [5:0]    pos_d_reg;
  logic          cap_reg;

  logic          oversize;
  logic          len_bad;
  logic [AW-1:0] len_eff;
  logic [5:0]    issue_p;
  logic          issue_rd;
  logic [15:0]   len_bits;
  logic [7:0]    byte_val;

  assign oversize = 8'(msg_length) > 8'(MAX_MESSAGE_LENGTH);
`ifdef MSG_LENGTH_CHECK_EN
  assign len_bad = oversize;
  assign len_eff = msg_length;
`else
  assign len_bad = 1'b0;
  assign len_eff = oversize ? AW'(MAX_MESSAGE_LENGTH) : msg_length;
`endif

  // Byte position to strobe next; the first read after start waits one cycle for len_reg.
  always_comb begin
    issue_p = 6'd0;
    case (state_reg)
      S_FETCH: issue_p = prime_reg ? {word_index, 2'b00} : ({word_index, cnt_reg} + 6'd1);
      S_EMIT:  issue_p = {word_index + 4'd1, 2'b00};
      default: issue_p = 6'd0;
    endcase
  end

  assign issue_rd = 8'(issue_p) < 8'(len_reg);
  assign len_bits = 16'(len_reg) << 3;

  // Padded byte for the position strobed in the previous cycle.
  always_comb begin
    byte_val = 8'h00;
    if (8'(pos_d_reg) < 8'(len_reg))       byte_val = mem_data;
    else if (8'(pos_d_reg) == 8'(len_reg)) byte_val = 8'h80;
    else if (pos_d_reg == 6'd62)           byte_val = len_bits[15:8];
    else if (pos_d_reg == 6'd63)           byte_val = len_bits[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= 2'd0;
      prime_reg  <= 1'b0;
      len_reg    <= '0;
      pos_d_reg  <= 6'd0;
      cap_reg    <= 1'b0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      word_out   <= 32'd0;
      word_index <= 4'd0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef MSG_LENGTH_CHECK_EN
      len_error  <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      cap_reg <= 1'b0;
`ifdef MSG_LENGTH_CHECK_EN
      len_error <= start && (state_reg == S_IDLE) && oversize;
`endif
      if (cap_reg) word_out <= {word_out[23:0], byte_val};
      case (state_reg)
        S_IDLE: begin
          if (start && !len_bad) begin
            len_reg    <= len_eff;
            state_reg  <= S_FETCH;
            prime_reg  <= 1'b1;
            cnt_reg    <= 2'd0;
            word_index <= 4'd0;
            busy       <= 1'b1;
          end
        end
        S_FETCH: begin
          if (prime_reg) begin
            prime_reg <= 1'b0;
            mem_rd_en <= issue_rd;
            if (issue_rd) mem_addr <= AW'(issue_p);
          end else begin
            pos_d_reg <= {word_index, cnt_reg};
            cap_reg   <= 1'b1;
            if (cnt_reg == 2'd3) begin
              mem_rd_en <= 1'b0;
              state_reg <= S_WAIT;
            end else begin
              cnt_reg   <= cnt_reg + 2'd1;
              mem_rd_en <= issue_rd;
              if (issue_rd) mem_addr <= AW'(issue_p);
            end
          end
        end
        S_WAIT: begin
          word_valid <= 1'b1;
          state_reg  <= S_EMIT;
        end
        S_EMIT: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            if (word_index == 4'd15) begin
              state_reg <= S_DONE;
              done      <= 1'b1;
            end else begin
              state_reg  <= S_FETCH;
              cnt_reg    <= 2'd0;
              word_index <= word_index + 4'd1;
              mem_rd_en  <= issue_rd;
              if (issue_rd) mem_addr <= AW'(issue_p);
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_block_ctrl.sv
// Bench for sha256_msg_block_ctrl: vector table, hand sequences and random blocks vs a padding model.
module tb_sha256_msg_block_ctrl;
  localparam int MAXL = 55;
  localparam int AW = $clog2(MAXL) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] msg_length = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [7:0]    mem_data = 8'h00;
  logic [31:0]   word_out;
  logic [3:0]    word_index;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic          busy;
  logic          done;
`ifdef MSG_LENGTH_CHECK_EN
  logic          len_error;
`endif

  sha256_msg_block_ctrl #(.MAX_MESSAGE_LENGTH(MAXL)) dut (
    .clock(clock), .reset(reset), .start(start), .msg_length(msg_length),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
    .word_out(word_out), .word_index(word_index), .word_valid(word_valid),
    .word_ready(word_ready), .busy(busy),
`ifdef MSG_LENGTH_CHECK_EN
    .done(done), .len_error(len_error)
`else
    .done(done)
`endif
  );

  always #5 clock = ~clock;

  logic [7:0]  mem_model [64];
  int          rd_log [$];
  logic [31:0] exp_words [16];
  logic [31:0] got_words [16];
  int          exp_len;
  int          n_pass = 0;
  int          n_total = 0;

  // Byte memory with one cycle of read latency.
  always @(posedge clock) begin
    if (mem_rd_en) begin
      mem_data <= mem_model[mem_addr[5:0]];
      rd_log.push_back(int'(mem_addr));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic fill_mem(input int mode);
    for (int i = 0; i < 64; i++) begin
      case (mode)
        0:       mem_model[i] = (i < 3) ? 8'(8'h61 + i) : 8'($urandom);
        1:       mem_model[i] = 8'(i);
        default: mem_model[i] = 8'($urandom);
      endcase
    end
  endtask

  // Padded block from message bytes, 0x80 marker and 64-bit bit length.
  task automatic compute_expected(input int len_in);
    int l;
    logic [7:0] b [64];
    logic [63:0] bitlen;
    l = (len_in > MAXL) ? MAXL : len_in;
    bitlen = 64'(l) * 64'd8;
    for (int i = 0; i < 64; i++)
      b[i] = (i < l) ? mem_model[i] : ((i == l) ? 8'h80 : 8'h00);
    for (int j = 0; j < 8; j++) b[56 + j] = bitlen[63 - 8*j -: 8];
    for (int k = 0; k < 16; k++) exp_words[k] = {b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]};
    exp_len = l;
  endtask

  // ready_mode: 0 always ready, 1 random, 2 stall stall_cycles at stall_word then ready.
  task automatic run_block(input int len, input int ready_mode, input int stall_word,
                           input int stall_cycles, input string tag);
    int k = 0, c = -1, acc_edge = 0, lat_bad = 0, hold_bad = 0, idx_bad = 0;
    int done_cnt = 0, done_cycle = -1, stall_left, rd_bad = 0;
    bit seen_valid = 0, finished = 0, timeout = 0, rdy;
    logic busy_first = 1'b0, busy_after = 1'b1;
    logic [31:0] held_w = 32'd0;
    logic [3:0]  held_i = 4'd0;
    compute_expected(len);
    for (int i = 0; i < 16; i++) got_words[i] = 32'hDEADBEEF;
    stall_left = stall_cycles;
    rd_log.delete();
    @(negedge clock);
    start = 1'b1; msg_length = AW'(len); word_ready = 1'b0;
    @(posedge clock); #1;
    start = 1'b0; msg_length = AW'($urandom);
    while (!finished) begin
      @(negedge clock); c++;
      if (c > 600) begin timeout = 1; break; end
      if (c == 0) busy_first = busy;
      if (done) begin done_cnt++; done_cycle = c; end
      if (word_valid) begin
        if (!seen_valid) begin
          seen_valid = 1; held_w = word_out; held_i = word_index;
          if (c - acc_edge != ((k == 0) ? 6 : 5)) lat_bad++;
        end else if (word_out !== held_w || word_index !== held_i) hold_bad++;
        rdy = (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (ready_mode == 2 && k == stall_word && stall_left > 0) begin rdy = 0; stall_left--; end
        word_ready = rdy;
        if (rdy) begin
          if (k < 16) got_words[k] = word_out;
          if (word_index !== 4'(k)) idx_bad++;
          acc_edge = c + 1; seen_valid = 0; k++;
        end
      end else begin
        if (seen_valid) hold_bad++;
        word_ready = 1'($urandom_range(0, 1));
        if (k == 16 && c == acc_edge + 1) begin busy_after = busy; finished = 1; end
      end
    end
    word_ready = 1'b0;
    check({tag, " timeout"}, 32'(timeout), 32'd0);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s word%0d", tag, i), got_words[i], exp_words[i]);
    check({tag, " word_index"}, 32'(idx_bad), 32'd0);
    check({tag, " latency"}, 32'(lat_bad), 32'd0);
    check({tag, " hold_stable"}, 32'(hold_bad), 32'd0);
    check({tag, " busy_start"}, 32'(busy_first), 32'd1);
    check({tag, " done_count"}, 32'(done_cnt), 32'd1);
    check({tag, " done_cycle"}, 32'(done_cycle), 32'(acc_edge));
    check({tag, " busy_after"}, 32'(busy_after), 32'd0);
    check({tag, " read_count"}, 32'(rd_log.size()), 32'(exp_len));
    for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] != i) rd_bad++;
    check({tag, " read_order"}, 32'(rd_bad), 32'd0);
  endtask

  typedef struct {
    int len; int data_mode; int ready_mode; int stall_word; int stall_cycles;
    logic [31:0] w0; logic [31:0] w13; logic [31:0] w15;
  } vec_t;
  vec_t vecs [$];

  initial begin
    bit hit;
    vecs.push_back('{3,  0, 0, 0, 0,  32'h61626380, 32'h00000000, 32'h00000018});
    vecs.push_back('{0,  1, 0, 0, 0,  32'h80000000, 32'h00000000, 32'h00000000});
    vecs.push_back('{55, 1, 0, 0, 0,  32'h00010203, 32'h34353680, 32'h000001B8});
    vecs.push_back('{8,  1, 2, 2, 10, 32'h00010203, 32'h00000000, 32'h00000040});
    vecs.push_back('{4,  1, 1, 0, 0,  32'h00010203, 32'h00000000, 32'h00000020});
    vecs.push_back('{52, 1, 1, 0, 0,  32'h00010203, 32'h80000000, 32'h000001A0});
`ifndef MSG_LENGTH_CHECK_EN
    vecs.push_back('{60, 1, 0, 0, 0,  32'h00010203, 32'h34353680, 32'h000001B8});
`endif

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst word_valid", 32'(word_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst word_out", word_out, 32'd0);
    check("rst word_index", 32'(word_index), 32'd0);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    check("idle busy", 32'(busy), 32'd0);

    foreach (vecs[v]) begin
      fill_mem(vecs[v].data_mode);
      run_block(vecs[v].len, vecs[v].ready_mode, vecs[v].stall_word, vecs[v].stall_cycles,
                $sformatf("vec%0d L=%0d", v, vecs[v].len));
      check($sformatf("vec%0d const w0", v), got_words[0], vecs[v].w0);
      check($sformatf("vec%0d const w13", v), got_words[13], vecs[v].w13);
      check($sformatf("vec%0d const w15", v), got_words[15], vecs[v].w15);
      $display("vec%0d L=%0d done", v, vecs[v].len);
    end

    // Reset in the middle of word 5 of a 20-byte block, then a clean block.
    fill_mem(1);
    rd_log.delete();
    @(negedge clock);
    start = 1'b1; msg_length = AW'(20); word_ready = 1'b1;
    @(negedge clock); start = 1'b0;
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clock);
      if (word_valid && word_index == 4'd5) hit = 1;
    end
    check("midrst reached word5", 32'(hit), 32'd1);
    word_ready = 1'b0; reset = 1'b0; #1;
    check("midrst word_valid", 32'(word_valid), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst word_out", word_out, 32'd0);
    check("midrst mem_rd_en", 32'(mem_rd_en), 32'd0);
    @(negedge clock);
    check("midrst done", 32'(done), 32'd0);
    reset = 1'b1;
    fill_mem(0);
    run_block(3, 0, 0, 0, "after_rst L=3");
    $display("reset-recovery block done");

`ifdef MSG_LENGTH_CHECK_EN
    rd_log.delete();
    @(negedge clock); start = 1'b1; msg_length = AW'(60);
    @(posedge clock); #1; start = 1'b0;
    check("oversize len_error", 32'(len_error), 32'd1);
    check("oversize busy", 32'(busy), 32'd0);
    @(negedge clock); @(negedge clock);
    check("oversize pulse end", 32'(len_error), 32'd0);
    check("oversize busy later", 32'(busy), 32'd0);
    check("oversize reads", 32'(rd_log.size()), 32'd0);
    $display("oversize start rejected sequence done");
`endif

    for (int r = 0; r < 8; r++) begin
      int l;
      l = $urandom_range(0, MAXL);
      fill_mem(2);
      run_block(l, 1, 0, 0, $sformatf("rand%0d L=%0d", r, l));
      $display("rand%0d L=%0d done", r, l);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
